// File: rtl/dmem_rmw_ctrl.sv
// rtl/dmem_rmw_ctrl.sv - MEM-stage data RAM responder with byte/halfword read-modify-write
// Optional DMEM_MISALIGN_CHK_EN adds the misalign port and suppresses misaligned accesses.
module dmem_rmw_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [2:0]        req_funct3,
   input  logic [DATA_W-1:0] req_wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              pipe_ready_go
`ifdef DMEM_MISALIGN_CHK_EN
   ,
   output logic              misalign
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD_RSP, ST_MERGE} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] mem_rd;
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] load_fmt;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        off;
   logic              is_byte;
   logic              is_half;
   logic              is_word;
   logic              is_sub_store;
   logic              bad_align;
   logic              accept;
   logic              mem_we;
   logic              unused_addr_hi;

   assign idx            = req_addr[ADDR_W+1:2];
   assign off            = req_addr[1:0];
   assign unused_addr_hi = ^req_addr[DATA_W-1:ADDR_W+2];

   // Codes outside the listed sizes fall through to word access for both loads and stores.
   assign is_byte      = (req_funct3 == 3'b000) || (!req_we && req_funct3 == 3'b100);
   assign is_half      = (req_funct3 == 3'b001) || (!req_we && req_funct3 == 3'b101);
   assign is_word      = !is_byte && !is_half;
   assign is_sub_store = req_we && !is_word;

`ifdef DMEM_MISALIGN_CHK_EN
   assign bad_align = (is_half && off[0]) || (is_word && (off != 2'b00));
   assign misalign  = (state == IDLE) && req_valid && bad_align;
`else
   assign bad_align = 1'b0;
`endif

   assign accept        = (state == IDLE) && req_valid && !bad_align;
   assign pipe_ready_go = !(accept && (!req_we || is_sub_store));

   assign mem_rd    = mem[idx];
   assign mem_we    = rst_n && ((accept && req_we && is_word) || (state == ST_MERGE));
   assign mem_wdata = (state == ST_MERGE) ? merged : req_wdata;

   always_comb begin
      byte_v = mem_rd[{off, 3'b000} +: 8];
      half_v = mem_rd[{off[1], 4'b0000} +: 16];
      case (req_funct3)
         3'b000:  load_fmt = {{(DATA_W-8){byte_v[7]}}, byte_v};
         3'b001:  load_fmt = {{(DATA_W-16){half_v[15]}}, half_v};
         3'b100:  load_fmt = {{(DATA_W-8){1'b0}}, byte_v};
         3'b101:  load_fmt = {{(DATA_W-16){1'b0}}, half_v};
         default: load_fmt = mem_rd;
      endcase
   end

   always_comb begin
      merged = ram_q;
      if (is_byte)
         merged[{off, 3'b000} +: 8] = req_wdata[7:0];
      else
         merged[{off[1], 4'b0000} +: 16] = req_wdata[15:0];
   end

   // RAM array and its read register are not reset; write-back is gated so reset drops it.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[idx] <= mem_wdata;
      if (accept && is_sub_store)
         ram_q <= mem_rd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rdata       <= '0;
         rdata_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rdata_valid <= 1'b0;
               if (accept && !req_we) begin
                  rdata       <= load_fmt;
                  rdata_valid <= 1'b1;
                  state       <= LOAD_RSP;
               end else if (accept && is_sub_store) begin
                  state <= ST_MERGE;
               end
            end
            LOAD_RSP: begin
               rdata_valid <= 1'b0;
               state       <= IDLE;
            end
            ST_MERGE: begin
               rdata_valid <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               rdata_valid <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// tb/tb_dmem_rmw_ctrl.sv - scoreboard bench for dmem_rmw_ctrl
// Covers DMEM_MISALIGN_CHK_EN builds as well as the default build.
module tb_dmem_rmw_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic [31:0] req_wdata;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        pipe_ready_go;
`ifdef DMEM_MISALIGN_CHK_EN
   logic        misalign;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] sb_q[$];

   dmem_rmw_ctrl #(.DATA_W(32), .ADDR_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_funct3    (req_funct3),
      .req_wdata     (req_wdata),
      .rdata         (rdata),
      .rdata_valid   (rdata_valid),
      .pipe_ready_go (pipe_ready_go)
`ifdef DMEM_MISALIGN_CHK_EN
      ,
      .misalign      (misalign)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every rdata_valid pulse consumes one expected load result.
   always @(negedge clk) begin
      if (rst_n && rdata_valid) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rdata_valid: got rdata %h expected no response", rdata);
         end else begin
            chk("load_rdata", rdata, sb_q.pop_front());
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, input int exp_stall, input logic exp_mis);
      int  stall;
      bit  done;
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_funct3 = f3;
      req_wdata  = wd;
      stall      = 0;
      done       = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         @(negedge clk);
`ifdef DMEM_MISALIGN_CHK_EN
         if (i == 0) chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
`endif
         if (pipe_ready_go) done = 1'b1;
         else stall++;
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL stall_timeout: got no pipe_ready_go in 8 cycles expected %0d stall", exp_stall);
      end else begin
         chk("stall_cycles", stall, exp_stall);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic st(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                     input int exp_stall);
      do_req(1'b1, addr, f3, wd, exp_stall, 1'b0);
   endtask

   task automatic ld(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] exp);
      sb_q.push_back(exp);
      do_req(1'b0, addr, f3, 32'd0, 1, 1'b0);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_funct3 = '0;
      req_wdata  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_rdata_valid", {31'd0, rdata_valid}, 32'd0);
      chk("reset_ready", {31'd0, pipe_ready_go}, 32'd1);
`ifdef DMEM_MISALIGN_CHK_EN
      chk("reset_misalign", {31'd0, misalign}, 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      st(32'h10, 3'b010, 32'h8765_4321, 0);
      ld(32'h10, 3'b010, 32'h8765_4321);
      st(32'h11, 3'b000, 32'hFFFF_FFAB, 1);
      ld(32'h10, 3'b010, 32'h8765_AB21);
      st(32'h12, 3'b001, 32'h1234_F00D, 1);
      ld(32'h12, 3'b001, 32'hFFFF_F00D);
      ld(32'h12, 3'b101, 32'h0000_F00D);
      ld(32'h13, 3'b000, 32'hFFFF_FFF0);
      ld(32'h13, 3'b100, 32'h0000_00F0);
      ld(32'h11, 3'b000, 32'hFFFF_FFAB);
      ld(32'h10, 3'b100, 32'h0000_0021);
      ld(32'h10, 3'b001, 32'hFFFF_AB21);

      st(32'h400, 3'b010, 32'hCAFE_BABE, 0);
      ld(32'h000, 3'b010, 32'hCAFE_BABE);
      st(32'h3FC, 3'b010, 32'h1357_9BDF, 0);
      ld(32'h3FC, 3'b010, 32'h1357_9BDF);
      ld(32'hFFFF_F3FC, 3'b010, 32'h1357_9BDF);
      ld(32'h10, 3'b010, 32'hF00D_AB21);

      st(32'h30, 3'b111, 32'h0BAD_F00D, 0);
      ld(32'h30, 3'b011, 32'h0BAD_F00D);

      // Reset during the write-back cycle of a byte store.
      st(32'h20, 3'b010, 32'h1111_1111, 0);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_addr   = 32'h20;
      req_funct3 = 3'b000;
      req_wdata  = 32'h55;
      @(negedge clk);
      chk("sb_stall_before_reset", {31'd0, pipe_ready_go}, 32'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      chk("midreset_ready", {31'd0, pipe_ready_go}, 32'd1);
      chk("midreset_rdata", rdata, 32'd0);
      chk("midreset_rdata_valid", {31'd0, rdata_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      ld(32'h20, 3'b010, 32'h1111_1111);

`ifdef DMEM_MISALIGN_CHK_EN
      do_req(1'b0, 32'h22, 3'b010, 32'd0, 0, 1'b1);
      @(negedge clk);
      chk("misaligned_load_rdata_held", rdata, 32'h1111_1111);
      @(posedge clk);
      #1;
      do_req(1'b1, 32'h21, 3'b001, 32'h0000_BEEF, 0, 1'b1);
      ld(32'h20, 3'b010, 32'h1111_1111);
`else
      ld(32'h22, 3'b010, 32'h1111_1111);
      st(32'h21, 3'b001, 32'h0000_BEEF, 1);
      ld(32'h20, 3'b010, 32'h1111_BEEF);
`endif

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
